matmul_tile_sequencer: RTL and testbench
========================================

# matmul_tile_sequencer

Sequencer that drives a tiled MAC datapath for C = A·B with irregular shapes (M×K times K×N, any dimension ≥1, not necessarily a multiple of the tile size). It accepts one job descriptor, walks row tiles, column tiles and K-slices in a fixed order, and issues one tile command per K-slice over a valid/ready handshake. Each command carries edge-clipped extents plus accumulator clear and write-back flags. It sits between the job/config front end and the matmul datapath.

## Interface
- DIM_W, 16, width of M/K/N and of all coordinates
- TILE_M, 4, rows per output tile
- TILE_N, 4, columns per output tile
- TILE_K, 8, reduction depth per command
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- cfg_valid  in  1  job descriptor valid
- cfg_ready  out  1  sequencer idle, descriptor accepted on valid&ready
- cfg_m, cfg_k, cfg_n  in  DIM_W each  job dimensions
- abort  in  1  cancel current job
- cmd_valid  out  1  tile command valid
- cmd_ready  in  1  datapath accepts command
- cmd_row, cmd_col, cmd_kofs  out  DIM_W each  tile origin (row of C, column of C, K offset)
- cmd_rows  out  $clog2(TILE_M+1)  valid rows in tile, 1..TILE_M
- cmd_cols  out  $clog2(TILE_N+1)  valid columns, 1..TILE_N
- cmd_kcnt  out  $clog2(TILE_K+1)  valid K depth, 1..TILE_K
- cmd_first  out  1  clear accumulator before this slice
- cmd_last  out  1  write tile result after this slice
- busy  out  1  job in progress
- done  out  1  one-cycle pulse, job completed
- err  out  1  one-cycle pulse, descriptor rejected

## Operation
- FSM states: IDLE, ISSUE, DONE.
- IDLE: cfg_ready=1. On cfg_valid: if any of M, K, N is 0, pulse err next cycle and stay IDLE; else latch dims, clear counters, go to ISSUE.
- ISSUE: cmd_valid=1, busy=1. On handshake, advance the innermost counter first: kofs += TILE_K; on K wrap, col += TILE_N; on N wrap, row += TILE_M. Handshake on the final command (last row tile, last col tile, last K-slice) → DONE.
- DONE: done=1 and busy=1 for one cycle, then IDLE.
- Extents: cmd_rows=min(TILE_M, M−row), cmd_cols=min(TILE_N, N−col), cmd_kcnt=min(TILE_K, K−kofs).
- Flags: cmd_first=(kofs==0); cmd_last=(kofs+TILE_K ≥ K). Both are 1 when K ≤ TILE_K.
- Arithmetic: compare and advance in DIM_W+1 bits so that row+TILE_M etc. never wrap. Dims up to 2^DIM_W−1 are legal.
- Command count per job = ceil(M/TILE_M)·ceil(N/TILE_N)·ceil(K/TILE_K).
- Abort in ISSUE or DONE: next state IDLE; cmd_valid drops; no done pulse. Abort beats a same-cycle handshake, and that command counts as not issued. Abort in IDLE has no effect.

## Timing
- Reset values: cfg_ready=1; cmd_valid=0; busy=0; done=0; err=0; all cmd_* fields 0.
- Descriptor accepted at cycle t → cmd_valid=1 at t+1 with the first command.
- With cmd_ready held high, the sequencer issues one command per cycle with no bubbles.
- While cmd_valid && !cmd_ready, all cmd_* fields stay stable. cmd_valid never drops without a handshake, except on abort or rst.
- Final handshake at t → done=1 at t+1 → cfg_ready=1 at t+2.
- err pulses at t+1 after a rejected descriptor at t; cfg_ready stays 1 throughout.
- rst mid-job returns the block to reset values on the next edge, with no done pulse.
- All outputs are registered.

## Configuration
- MATMUL_SEQ_PERF_EN defined: adds output perf_stall (32-bit, count of cycles with cmd_valid && !cmd_ready) and output perf_cmds (32-bit, count of handshakes). Both counters clear on rst and on descriptor acceptance, and saturate at all-ones.
- Not defined: those ports and counters are absent. All other behaviour is identical.

## Test plan
- Defaults, M=5 K=9 N=3, cmd_ready=1 → exactly 4 commands on consecutive cycles, (row,col,kofs,rows,cols,kcnt,first,last):
  - (0,0,0,4,3,8,1,0)
  - (0,0,8,4,3,1,0,1)
  - (4,0,0,1,3,8,1,0)
  - (4,0,8,1,3,1,0,1)
  - then done at the following cycle, cfg_ready one cycle later.
- M=4 K=8 N=4 → one command (0,0,0,4,4,8,1,1); busy high for 2 cycles.
- M=8 K=3 N=9, cmd_ready toggling randomly → 6 commands in col-inner order. cols=4,4,1 per row tile. Every command has first=last=1, and fields are stable during stalls.
- cfg_k=0 → err pulse one cycle later, no cmd_valid, cfg_ready stays 1. A following valid job runs normally.
- Abort asserted during the 2nd command of the M=5 K=9 N=3 job with cmd_ready=1 → only 1 handshake counted, cmd_valid=0 and cfg_ready=1 next cycle, no done. Repeat the same with rst in place of abort.
- With MATMUL_SEQ_PERF_EN: M=5 K=9 N=3 with cmd_ready low for 3 cycles before each command → perf_cmds=4, perf_stall=12 at done.

Source files
------------

// File: rtl/matmul_tile_sequencer.sv
// matmul_tile_sequencer
// Walks one C = A*B job (M x K times K x N) tile by tile: row tiles outermost,
// column tiles next, K-slices innermost. Each K-slice becomes one tile command
// on a valid/ready handshake. The command carries edge-clipped extents and
// accumulator clear (first) / write-back (last) flags.
// Optional feature: define MATMUL_SEQ_PERF_EN to add the perf_stall and
// perf_cmds saturating counters. Without it those ports do not exist.
module matmul_tile_sequencer #(
    parameter int DIM_W  = 16,
    parameter int TILE_M = 4,
    parameter int TILE_N = 4,
    parameter int TILE_K = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          cfg_valid,
    output logic                          cfg_ready,
    input  logic [DIM_W-1:0]              cfg_m,
    input  logic [DIM_W-1:0]              cfg_k,
    input  logic [DIM_W-1:0]              cfg_n,
    input  logic                          abort,
    output logic                          cmd_valid,
    input  logic                          cmd_ready,
    output logic [DIM_W-1:0]              cmd_row,
    output logic [DIM_W-1:0]              cmd_col,
    output logic [DIM_W-1:0]              cmd_kofs,
    output logic [$clog2(TILE_M+1)-1:0]   cmd_rows,
    output logic [$clog2(TILE_N+1)-1:0]   cmd_cols,
    output logic [$clog2(TILE_K+1)-1:0]   cmd_kcnt,
    output logic                          cmd_first,
    output logic                          cmd_last,
    output logic                          busy,
    output logic                          done,
    output logic                          err
`ifdef MATMUL_SEQ_PERF_EN
    ,
    output logic [31:0]                   perf_stall,
    output logic [31:0]                   perf_cmds
`endif
);

    localparam int RW = $clog2(TILE_M + 1);
    localparam int CW = $clog2(TILE_N + 1);
    localparam int KW = $clog2(TILE_K + 1);

    // Tile sizes widened by one bit so origin + tile never wraps.
    localparam logic [DIM_W:0] TM_X = (DIM_W + 1)'(TILE_M);
    localparam logic [DIM_W:0] TN_X = (DIM_W + 1)'(TILE_N);
    localparam logic [DIM_W:0] TK_X = (DIM_W + 1)'(TILE_K);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic [DIM_W-1:0] m_q, k_q, n_q;
    logic [DIM_W-1:0] m_next, k_next, n_next;
    logic [DIM_W-1:0] row_q, col_q, kofs_q;
    logic [DIM_W-1:0] row_next, col_next, kofs_next;
    logic             err_next;
    logic             handshake;

    logic [DIM_W:0]   row_sum, col_sum, kofs_sum;
    logic             row_end, col_end, k_end;

    logic [DIM_W:0]   rem_rows, rem_cols, rem_k;
    logic [RW-1:0]    rows_next;
    logic [CW-1:0]    cols_next;
    logic [KW-1:0]    kcnt_next;
    logic             first_next, last_next;

    // Where each counter would move next and whether it is on its final tile.
    always_comb begin
        row_sum  = {1'b0, row_q}  + TM_X;
        col_sum  = {1'b0, col_q}  + TN_X;
        kofs_sum = {1'b0, kofs_q} + TK_X;
        row_end  = row_sum  >= {1'b0, m_q};
        col_end  = col_sum  >= {1'b0, n_q};
        k_end    = kofs_sum >= {1'b0, k_q};
    end

    // Next-state and next-counter logic; abort wins over a same-cycle handshake.
    always_comb begin
        state_next = state;
        m_next     = m_q;
        k_next     = k_q;
        n_next     = n_q;
        row_next   = row_q;
        col_next   = col_q;
        kofs_next  = kofs_q;
        err_next   = 1'b0;
        handshake  = 1'b0;
        case (state)
            IDLE: begin
                if (cfg_valid) begin
                    if (cfg_m == '0 || cfg_k == '0 || cfg_n == '0) begin
                        err_next = 1'b1;
                    end else begin
                        m_next     = cfg_m;
                        k_next     = cfg_k;
                        n_next     = cfg_n;
                        row_next   = '0;
                        col_next   = '0;
                        kofs_next  = '0;
                        state_next = ISSUE;
                    end
                end
            end
            ISSUE: begin
                if (abort) begin
                    state_next = IDLE;
                end else if (cmd_ready) begin
                    handshake = 1'b1;
                    if (k_end && col_end && row_end) begin
                        state_next = DONE;
                    end else if (!k_end) begin
                        kofs_next = DIM_W'(kofs_sum);
                    end else if (!col_end) begin
                        kofs_next = '0;
                        col_next  = DIM_W'(col_sum);
                    end else begin
                        kofs_next = '0;
                        col_next  = '0;
                        row_next  = DIM_W'(row_sum);
                    end
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Clipped extents and flags for the command that will be presented next cycle.
    always_comb begin
        rem_rows   = {1'b0, m_next} - {1'b0, row_next};
        rem_cols   = {1'b0, n_next} - {1'b0, col_next};
        rem_k      = {1'b0, k_next} - {1'b0, kofs_next};
        rows_next  = (rem_rows >= TM_X) ? RW'(TILE_M) : RW'(rem_rows);
        cols_next  = (rem_cols >= TN_X) ? CW'(TILE_N) : CW'(rem_cols);
        kcnt_next  = (rem_k >= TK_X)    ? KW'(TILE_K) : KW'(rem_k);
        first_next = (kofs_next == '0);
        last_next  = ({1'b0, kofs_next} + TK_X) >= {1'b0, k_next};
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Job dimensions, tile counters and all registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            m_q       <= '0;
            k_q       <= '0;
            n_q       <= '0;
            row_q     <= '0;
            col_q     <= '0;
            kofs_q    <= '0;
            cfg_ready <= 1'b1;
            cmd_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            cmd_row   <= '0;
            cmd_col   <= '0;
            cmd_kofs  <= '0;
            cmd_rows  <= '0;
            cmd_cols  <= '0;
            cmd_kcnt  <= '0;
            cmd_first <= 1'b0;
            cmd_last  <= 1'b0;
        end else begin
            m_q       <= m_next;
            k_q       <= k_next;
            n_q       <= n_next;
            row_q     <= row_next;
            col_q     <= col_next;
            kofs_q    <= kofs_next;
            cfg_ready <= (state_next == IDLE);
            cmd_valid <= (state_next == ISSUE);
            busy      <= (state_next != IDLE);
            done      <= (state_next == DONE);
            err       <= err_next;
            if (state_next == ISSUE) begin
                cmd_row   <= row_next;
                cmd_col   <= col_next;
                cmd_kofs  <= kofs_next;
                cmd_rows  <= rows_next;
                cmd_cols  <= cols_next;
                cmd_kcnt  <= kcnt_next;
                cmd_first <= first_next;
                cmd_last  <= last_next;
            end
        end
    end

`ifdef MATMUL_SEQ_PERF_EN
    logic accept;
    assign accept = (state == IDLE) && (state_next == ISSUE);

    // Saturating stall and issued-command counters, cleared per accepted job.
    always_ff @(posedge clk) begin
        if (rst || accept) begin
            perf_stall <= '0;
            perf_cmds  <= '0;
        end else begin
            if (cmd_valid && !cmd_ready && perf_stall != '1) begin
                perf_stall <= perf_stall + 32'd1;
            end
            if (handshake && perf_cmds != '1) begin
                perf_cmds <= perf_cmds + 32'd1;
            end
        end
    end
`else
    logic unused_handshake;
    assign unused_handshake = handshake;
`endif

endmodule

// File: tb/tb_matmul_tile_sequencer.sv
// Self-checking bench for matmul_tile_sequencer. Expected tile commands are
// generated by a loop model when a job is driven, queued, and compared
// against every cycle the DUT presents a command.
module tb_matmul_tile_sequencer;

    localparam int DIM_W = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              cfg_valid;
    logic              cfg_ready;
    logic [DIM_W-1:0]  cfg_m, cfg_k, cfg_n;
    logic              abort;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [DIM_W-1:0]  cmd_row, cmd_col, cmd_kofs;
    logic [2:0]        cmd_rows, cmd_cols;
    logic [3:0]        cmd_kcnt;
    logic              cmd_first, cmd_last;
    logic              busy, done, err;
`ifdef MATMUL_SEQ_PERF_EN
    logic [31:0]       perf_stall, perf_cmds;
`endif

    int total = 0;
    int bad = 0;
    int hs_count = 0;
    int done_count = 0;
    bit rand_ready = 1'b0;
    logic [63:0] exp_q[$];

    matmul_tile_sequencer dut (
        .clk(clk), .rst(rst),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_m(cfg_m), .cfg_k(cfg_k), .cfg_n(cfg_n),
        .abort(abort),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_row(cmd_row), .cmd_col(cmd_col), .cmd_kofs(cmd_kofs),
        .cmd_rows(cmd_rows), .cmd_cols(cmd_cols), .cmd_kcnt(cmd_kcnt),
        .cmd_first(cmd_first), .cmd_last(cmd_last),
        .busy(busy), .done(done), .err(err)
`ifdef MATMUL_SEQ_PERF_EN
        ,
        .perf_stall(perf_stall), .perf_cmds(perf_cmds)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] pack(input int row, input int col, input int kofs,
                                         input int rows, input int cols, input int kcnt,
                                         input bit first, input bit last);
        logic [15:0] r16, c16, k16;
        logic [2:0]  r3, c3;
        logic [3:0]  k4;
        r16 = 16'(row); c16 = 16'(col); k16 = 16'(kofs);
        r3 = 3'(rows); c3 = 3'(cols); k4 = 4'(kcnt);
        return {4'b0, r16, c16, k16, r3, c3, k4, first, last};
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("[TB] FAIL %s got=%0h want=%0h at %0t", tag, got, want, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_ready) cmd_ready = 1'($urandom_range(0, 1));
    endtask

    // Drive one descriptor for a single cycle and queue the commands it should produce.
    task automatic applyStimulus(input int m, input int k, input int n);
        cfg_valid = 1'b1;
        cfg_m = 16'(m); cfg_k = 16'(k); cfg_n = 16'(n);
        if (m > 0 && k > 0 && n > 0) begin
            for (int r = 0; r < m; r += 4)
                for (int c = 0; c < n; c += 4)
                    for (int ko = 0; ko < k; ko += 8)
                        exp_q.push_back(pack(r, c, ko,
                            (m - r < 4) ? m - r : 4,
                            (n - c < 4) ? n - c : 4,
                            (k - ko < 8) ? k - ko : 8,
                            ko == 0, ko + 8 >= k));
        end
        tick();
        cfg_valid = 1'b0;
    endtask

    task automatic waitDone(input int limit, output int n);
        n = 0;
        while (!done && n < limit) begin
            tick();
            n++;
        end
    endtask

    // Compare every presented command against the queue head; pop on a real handshake.
    always @(negedge clk) begin
        if (!rst) begin
            if (done) done_count++;
            if (cmd_valid) begin
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_cmd", 64'd1, 64'd0);
                end else begin
                    checkOutput("cmd_fields",
                        pack(int'(cmd_row), int'(cmd_col), int'(cmd_kofs), int'(cmd_rows),
                             int'(cmd_cols), int'(cmd_kcnt), cmd_first, cmd_last),
                        exp_q[0]);
                    if (cmd_ready && !abort) begin
                        void'(exp_q.pop_front());
                        hs_count++;
                    end
                end
            end
        end
    end

    initial begin
        int n, hs0, dn0, cnt;
        rst = 1'b1; cfg_valid = 1'b0; cfg_m = '0; cfg_k = '0; cfg_n = '0;
        abort = 1'b0; cmd_ready = 1'b1;
        repeat (3) tick();
        checkOutput("rst_cfg_ready", 64'(cfg_ready), 64'd1);
        checkOutput("rst_ctl", {61'd0, cmd_valid, busy, done | err}, 64'd0);
        checkOutput("rst_fields", pack(int'(cmd_row), int'(cmd_col), int'(cmd_kofs), int'(cmd_rows),
                    int'(cmd_cols), int'(cmd_kcnt), cmd_first, cmd_last), 64'd0);
        rst = 1'b0;
        tick();

        // Irregular job with back-to-back issue.
        $display("[TB] job 5x9x3, ready high");
        hs0 = hs_count;
        applyStimulus(5, 9, 3);
        checkOutput("t1_first_valid", 64'(cmd_valid), 64'd1);
        checkOutput("t1_busy", 64'(busy), 64'd1);
        waitDone(40, n);
        checkOutput("t1_done_latency", 64'(n), 64'd4);
        checkOutput("t1_hs", 64'(hs_count - hs0), 64'd4);
        checkOutput("t1_ready_in_done", 64'(cfg_ready), 64'd0);
        tick();
        checkOutput("t1_ready_after", 64'(cfg_ready), 64'd1);
        checkOutput("t1_done_pulse", 64'(done), 64'd0);
        checkOutput("t1_queue_empty", 64'(exp_q.size()), 64'd0);

        // Exactly one tile.
        $display("[TB] job 4x8x4");
        dn0 = done_count;
        applyStimulus(4, 8, 4);
        cnt = 0;
        while (busy && cnt < 10) begin
            cnt++;
            tick();
        end
        checkOutput("t2_busy_cycles", 64'(cnt), 64'd2);
        checkOutput("t2_done_count", 64'(done_count - dn0), 64'd1);
        checkOutput("t2_queue_empty", 64'(exp_q.size()), 64'd0);

        // Random backpressure; fields must hold during stalls.
        $display("[TB] job 8x3x9, random ready");
        hs0 = hs_count;
        rand_ready = 1'b1;
        applyStimulus(8, 3, 9);
        waitDone(300, n);
        checkOutput("t3_done_seen", 64'(done), 64'd1);
        rand_ready = 1'b0;
        cmd_ready = 1'b1;
        checkOutput("t3_hs", 64'(hs_count - hs0), 64'd6);
        checkOutput("t3_queue_empty", 64'(exp_q.size()), 64'd0);
        tick();

        // Rejected descriptor then a normal job.
        $display("[TB] zero K descriptor");
        applyStimulus(5, 0, 3);
        checkOutput("t4_err", 64'(err), 64'd1);
        checkOutput("t4_ready", 64'(cfg_ready), 64'd1);
        checkOutput("t4_no_valid", 64'(cmd_valid), 64'd0);
        tick();
        checkOutput("t4_err_pulse", 64'(err), 64'd0);
        hs0 = hs_count;
        applyStimulus(2, 2, 2);
        waitDone(20, n);
        checkOutput("t4_followup_latency", 64'(n), 64'd1);
        checkOutput("t4_followup_hs", 64'(hs_count - hs0), 64'd1);
        tick();

        // Abort during the second command.
        $display("[TB] abort mid-job");
        hs0 = hs_count; dn0 = done_count;
        applyStimulus(5, 9, 3);
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checkOutput("t5_valid", 64'(cmd_valid), 64'd0);
        checkOutput("t5_ready", 64'(cfg_ready), 64'd1);
        checkOutput("t5_busy", 64'(busy), 64'd0);
        checkOutput("t5_hs", 64'(hs_count - hs0), 64'd1);
        exp_q.delete();
        repeat (3) tick();
        checkOutput("t5_no_done", 64'(done_count - dn0), 64'd0);

        // Reset during the second command.
        $display("[TB] reset mid-job");
        hs0 = hs_count; dn0 = done_count;
        applyStimulus(5, 9, 3);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("t6_valid", 64'(cmd_valid), 64'd0);
        checkOutput("t6_ready", 64'(cfg_ready), 64'd1);
        checkOutput("t6_kofs", 64'(cmd_kofs), 64'd0);
        checkOutput("t6_hs", 64'(hs_count - hs0), 64'd1);
        exp_q.delete();
        repeat (3) tick();
        checkOutput("t6_no_done", 64'(done_count - dn0), 64'd0);

`ifdef MATMUL_SEQ_PERF_EN
        // Three stall cycles before every command.
        $display("[TB] perf counters");
        cmd_ready = 1'b0;
        applyStimulus(5, 9, 3);
        for (int c = 0; c < 4; c++) begin
            repeat (3) tick();
            cmd_ready = 1'b1;
            tick();
            cmd_ready = 1'b0;
        end
        checkOutput("t7_done", 64'(done), 64'd1);
        checkOutput("t7_perf_cmds", 64'(perf_cmds), 64'd4);
        checkOutput("t7_perf_stall", 64'(perf_stall), 64'd12);
        cmd_ready = 1'b1;
        tick();
`endif

        repeat (2) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
